logic_reduce_unit: RTL

- Parametrised, registered successor to the two-input gate primitives in Gate_Level.
- Folds a stream of WIDTH-bit operands into one result using a selectable bitwise operation: AND, OR, XOR, or pass-last, each with optional output inversion, which gives NAND/NOR/XNOR.
- Sits between a valid/ready producer and consumer. Emits one result per frame, together with the operand count.

---
 rtl/logic_pkg.sv | 38 +++
 rtl/logic_fold_alu.sv | 22 ++
 rtl/logic_reduce_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pkg
//  Description : Shared encodings, FSM state type and bitwise fold helper
//                for the logic reduction blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    // Widest operand the fold helper supports; callers zero-extend and slice.
    localparam int FOLD_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic logic [FOLD_MAX_W-1:0] logic_fold(
        input logic [1:0]            op,
        input logic [FOLD_MAX_W-1:0] a,
        input logic [FOLD_MAX_W-1:0] b
    );
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return b;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_fold_alu.sv
`default_nettype none
// ============================================================================
//  Module      : logic_fold_alu
//  Description : Combinational WIDTH-bit AND/OR/XOR/pass selector.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_fold_alu
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    // WIDTH must not exceed FOLD_MAX_W.
    assign y_o = WIDTH'(logic_fold(op_i, FOLD_MAX_W'(a_i), FOLD_MAX_W'(b_i)));

endmodule
`default_nettype wire

// File: rtl/logic_reduce_unit.sv
`default_nettype none
// ============================================================================
//  Module      : logic_reduce_unit
//  Description : Folds a valid/ready operand stream into one registered
//                result per frame, with operand count and truncation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_reduce_unit
    import logic_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 16,
    localparam int CW     = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op_sel_i,
    input  logic             inv_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CW-1:0]    out_count_o,
    output logic             out_trunc_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             inv_q, inv_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_trunc_q, out_trunc_d;

    logic             w_in_beat;
    logic             w_first;
    logic [1:0]       w_alu_op;
    logic             w_inv;
    logic [CW-1:0]    w_count_nx;
    logic             w_limit;
    logic [WIDTH-1:0] w_fold;

    // The first beat of a frame loads the operand as-is and uses the live
    // op_sel/inv; later beats use the values latched on that first beat.
    assign w_in_beat  = in_valid_i & in_ready_q;
    assign w_first    = (state_q == IDLE);
    assign w_alu_op   = w_first ? OP_PASS : op_q;
    assign w_inv      = w_first ? inv_i : inv_q;
    assign w_count_nx = w_first ? CW'(1) : count_q + CW'(1);
    assign w_limit    = (w_count_nx == CW'(MAX_OPS));

    logic_fold_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i (w_alu_op),
        .a_i  (acc_q),
        .b_i  (in_data_i),
        .y_o  (w_fold)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        op_d        = op_q;
        inv_d       = inv_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_trunc_d = out_trunc_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (w_in_beat) begin
                    acc_d   = w_fold;
                    count_d = w_count_nx;
                    if (w_first) begin
                        op_d  = op_sel_i;
                        inv_d = inv_i;
                    end
                    if (in_last_i || w_limit) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = w_fold ^ {WIDTH{w_inv}};
                        out_count_d = w_count_nx;
                        out_trunc_d = w_limit & ~in_last_i;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_d = (state_d != HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            op_q        <= OP_AND;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            op_q        <= op_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;
    assign out_trunc_o = out_trunc_q;

endmodule
`default_nettype wire
